regex_imem_arbiter_rr: RTL and testbench

- Shares one single-read-port instruction memory between 2**N_REQ_BITS pipelined regex CPU cores.
- Each core's fetch port (memory_valid / memory_addr / memory_ready, data sampled one cycle after handshake) connects to one requester slot.
- Work-conserving round-robin grant per cycle; read data broadcast back with one-hot per-requester data-valid strobe.
- Sits between the CPU array and the instruction BRAM wrapper.

---
 rtl/regex_arb_package.sv | 43 ++++
 rtl/rr_pick_comb.sv | 25 ++
 rtl/regex_imem_arbiter_rr.sv | 149 ++++++++++++++
 tb/tb_regex_imem_arbiter_rr.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/regex_arb_package.sv
// Shared definitions for the instruction-memory round-robin arbiter:
// fixed read latency, one-hot decode and the rotate-priority search.
package regex_arb_package;

    // Instruction memory returns data exactly this many cycles after a handshake.
    localparam int unsigned REGEX_IMEM_LATENCY = 32'd1;

    // Widest requester vector the helpers support (N_REQ_BITS up to 5).
    localparam int unsigned RR_MAX_REQ = 32'd32;

    // One-hot vector with only bit 'id' set.
    function automatic logic [RR_MAX_REQ-1:0] onehot_from_id(input int unsigned id);
        logic [RR_MAX_REQ-1:0] vec;
        vec = '0;
        vec[id[4:0]] = 1'b1;
        return vec;
    endfunction

    // First set bit of 'valid' searching upward from 'ptr', modulo n_req
    // (n_req is a power of two). Returns ptr when nothing is valid.
    function automatic int unsigned rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                            input int unsigned ptr,
                                            input int unsigned n_req);
        int unsigned winner;
        int unsigned idx;
        winner = ptr;
        // Walk from the far end so the closest hit to ptr is written last.
        for (int unsigned k = RR_MAX_REQ; k > 32'd0; k--) begin
            if ((k - 32'd1) < n_req) begin
                idx = (ptr + (k - 32'd1)) & (n_req - 32'd1);
                if (valid[idx[4:0]]) begin
                    winner = idx;
                end else begin
                    winner = winner;
                end
            end else begin
                winner = winner;
            end
        end
        return winner;
    endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Rotating-priority encoder: picks the first valid requester at or after
// the round-robin pointer. Purely combinational, N_REQ-generic.
module rr_pick_comb
    import regex_arb_package::*;
#(
    parameter  int unsigned N_REQ_BITS = 2,
    localparam int unsigned N_REQ      = 32'd1 << N_REQ_BITS,
    localparam int unsigned ID_W       = (N_REQ_BITS > 0) ? N_REQ_BITS : 32'd1
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [ID_W-1:0]  winner_o,
    output logic             any_o
);

    int unsigned pick_s;

    // Rotate-search from the pointer; idle cycles resolve to the pointer slot.
    always_comb begin
        pick_s   = rr_pick(RR_MAX_REQ'(valid_i), 32'(ptr_i), N_REQ);
        winner_o = ID_W'(pick_s);
        any_o    = |valid_i;
    end

endmodule

// File: rtl/regex_imem_arbiter_rr.sv
// Round-robin arbiter sharing one single-read-port instruction memory among
// 2**N_REQ_BITS regex cores. Grant is combinational and work-conserving,
// read data is broadcast with a one-hot per-slot strobe one cycle later.
// Optional per-slot grant counters: define REGEX_IMEM_ARB_STATS_EN.
module regex_imem_arbiter_rr
    import regex_arb_package::*;
#(
    parameter  int unsigned N_REQ_BITS        = 2,
    parameter  int unsigned MEMORY_ADDR_WIDTH = 11,
    parameter  int unsigned MEMORY_WIDTH      = 16,
    parameter  int unsigned STATS_WIDTH       = 16,
    localparam int unsigned N_REQ             = 32'd1 << N_REQ_BITS,
    // Slot-id width; equals N_REQ_BITS except for the single-requester build.
    localparam int unsigned ID_W              = (N_REQ_BITS > 0) ? N_REQ_BITS : 32'd1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
`ifdef REGEX_IMEM_ARB_STATS_EN
    input  logic                                 stats_clear,
    output logic [N_REQ*STATS_WIDTH-1:0]         grant_count,
`endif
    input  logic [N_REQ-1:0]                     req_valid,
    input  logic [N_REQ*MEMORY_ADDR_WIDTH-1:0]   req_addr,
    output logic [N_REQ-1:0]                     req_ready,
    output logic [MEMORY_WIDTH-1:0]              req_data,
    output logic [N_REQ-1:0]                     req_data_valid,
    output logic                                 mem_valid,
    output logic [MEMORY_ADDR_WIDTH-1:0]         mem_addr,
    input  logic                                 mem_ready,
    input  logic [MEMORY_WIDTH-1:0]              mem_data,
    output logic [ID_W-1:0]                      last_grant_id,
    output logic                                 busy
);

    logic [ID_W-1:0]  rr_ptr_q,     rr_ptr_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;
    logic [N_REQ-1:0] dvalid_q,     dvalid_d;
    logic             busy_q,       busy_d;

    logic [ID_W-1:0]  winner_s;
    logic             any_s;
    logic [N_REQ-1:0] grant_oh_s;
    logic             hs_s;

    // Winner select depends only on req_valid and the pointer, never mem_ready.
    rr_pick_comb #(
        .N_REQ_BITS (N_REQ_BITS)
    ) u_pick (
        .valid_i  (req_valid),
        .ptr_i    (rr_ptr_q),
        .winner_o (winner_s),
        .any_o    (any_s)
    );

    // Request steering: address mux, ready fan-out, handshake detect.
    always_comb begin
        grant_oh_s = N_REQ'(onehot_from_id(32'(winner_s)));
        mem_addr   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (winner_s == ID_W'(i)) begin
                mem_addr = req_addr[i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
            end else begin
                mem_addr = mem_addr;
            end
        end
        // Held reset forces the request side quiet.
        mem_valid = any_s & rst_n;
        req_ready = grant_oh_s & {N_REQ{mem_ready & mem_valid}};
        hs_s      = mem_valid & mem_ready;
        req_data  = mem_data;
    end

    // Next-state: advance pointer past the winner and arm the data strobe.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        last_grant_d = last_grant_q;
        dvalid_d     = '0;
        busy_d       = 1'b0;
        if (hs_s) begin
            if (N_REQ_BITS == 0) begin
                rr_ptr_d = '0;
            end else begin
                // ID_W == N_REQ_BITS here, so the add wraps N_REQ-1 -> 0.
                rr_ptr_d = winner_s + ID_W'(1);
            end
            last_grant_d = winner_s;
            dvalid_d     = grant_oh_s;
            busy_d       = 1'b1;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Arbiter state registers; reset discards any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            last_grant_q <= '0;
            dvalid_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            last_grant_q <= last_grant_d;
            dvalid_q     <= dvalid_d;
            busy_q       <= busy_d;
        end
    end

    assign req_data_valid = dvalid_q;
    assign busy           = busy_q;
    assign last_grant_id  = last_grant_q;

`ifdef REGEX_IMEM_ARB_STATS_EN
    logic [STATS_WIDTH-1:0] cnt_q [N_REQ];
    logic [STATS_WIDTH-1:0] cnt_d [N_REQ];

    // Saturating per-slot grant counters; clear beats a same-cycle increment.
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (stats_clear) begin
                cnt_d[i] = '0;
            end else if (hs_s && (winner_s == ID_W'(i)) && (cnt_q[i] != {STATS_WIDTH{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + STATS_WIDTH'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_stats_out
        assign grant_count[g*STATS_WIDTH +: STATS_WIDTH] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_regex_imem_arbiter_rr.sv
// Directed self-checking bench for regex_imem_arbiter_rr (4 requesters).
module tb_regex_imem_arbiter_rr;

    localparam int NB = 2;
    localparam int N  = 4;
    localparam int AW = 11;
    localparam int DW = 16;
    localparam int SW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   req_data;
    logic [N-1:0]    req_data_valid;
    logic            mem_valid;
    logic [AW-1:0]   mem_addr;
    logic            mem_ready;
    logic [DW-1:0]   mem_data;
    logic [NB-1:0]   last_grant_id;
    logic            busy;
`ifdef REGEX_IMEM_ARB_STATS_EN
    logic            stats_clear;
    logic [N*SW-1:0] grant_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] slot_addr [N];

    always #5 clk = ~clk;

    regex_imem_arbiter_rr #(
        .N_REQ_BITS        (NB),
        .MEMORY_ADDR_WIDTH (AW),
        .MEMORY_WIDTH      (DW),
        .STATS_WIDTH       (SW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
`ifdef REGEX_IMEM_ARB_STATS_EN
        .stats_clear    (stats_clear),
        .grant_count    (grant_count),
`endif
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .req_data       (req_data),
        .req_data_valid (req_data_valid),
        .mem_valid      (mem_valid),
        .mem_addr       (mem_addr),
        .mem_ready      (mem_ready),
        .mem_data       (mem_data),
        .last_grant_id  (last_grant_id),
        .busy           (busy)
    );

    // Memory stub: word is a fixed scramble of the address, one cycle after handshake.
    always @(posedge clk) begin
        if (mem_valid && mem_ready) mem_data <= {5'b0, mem_addr} ^ 16'hC3A5;
        else                        mem_data <= 16'hDEAD;
    end

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        return {5'b0, a} ^ 16'hC3A5;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        slot_addr[0] = 11'h010;
        slot_addr[1] = 11'h020;
        slot_addr[2] = 11'h030;
        slot_addr[3] = 11'h040;
        req_addr  = {11'h040, 11'h030, 11'h020, 11'h010};
        rst_n     = 1'b0;
        req_valid = 4'hF;
        mem_ready = 1'b1;
`ifdef REGEX_IMEM_ARB_STATS_EN
        stats_clear = 1'b0;
`endif
        tick();
        tick();
        // Reset state, with requests pending
        check_eq("rst_dvalid", 32'(req_data_valid), 32'h0);
        check_eq("rst_busy",   32'(busy),           32'h0);
        check_eq("rst_lgid",   32'(last_grant_id),  32'h0);
        check_eq("rst_ready",  32'(req_ready),      32'h0);
        check_eq("rst_mvalid", 32'(mem_valid),      32'h0);
        rst_n = 1'b1;

        // All four slots requesting: strict rotation 0,1,2,3,0,1,2,3
        for (int k = 0; k < 8; k++) begin
            #1;
            check_eq("rr_addr",  32'(mem_addr),  32'(slot_addr[k % 4]));
            check_eq("rr_ready", 32'(req_ready), 32'h1 << (k % 4));
            tick();
            check_eq("rr_lgid",   32'(last_grant_id),  32'(k % 4));
            check_eq("rr_dvalid", 32'(req_data_valid), 32'h1 << (k % 4));
            check_eq("rr_busy",   32'(busy),           32'h1);
            check_eq("rr_data",   32'(req_data),       32'(word_of(slot_addr[k % 4])));
        end

        // Slot 2 alone, mem_ready 1,0,1
        req_valid = 4'b0100;
        #1 check_eq("s2_ready_a", 32'(req_ready), 32'h4);
        tick();
        check_eq("s2_dvalid_a", 32'(req_data_valid), 32'h4);
        mem_ready = 1'b0;
        #1;
        check_eq("s2_ready_b",  32'(req_ready), 32'h0);
        check_eq("s2_mvalid_b", 32'(mem_valid), 32'h1);
        check_eq("s2_addr_b",   32'(mem_addr),  32'h030);
        tick();
        check_eq("s2_dvalid_b", 32'(req_data_valid), 32'h0);
        check_eq("s2_busy_b",   32'(busy),           32'h0);
        mem_ready = 1'b1;
        #1 check_eq("s2_ready_c", 32'(req_ready), 32'h4);
        tick();
        check_eq("s2_dvalid_c", 32'(req_data_valid), 32'h4);
        check_eq("s2_data_c",   32'(req_data),       32'(word_of(11'h030)));

        // Pointer at 3 with slots 1 and 3: 3 wins, then wraps to 1
        req_valid = 4'b1010;
        #1 check_eq("wr_ready_a", 32'(req_ready), 32'h8);
        tick();
        check_eq("wr_lgid_a", 32'(last_grant_id), 32'h3);
        #1 check_eq("wr_ready_b", 32'(req_ready), 32'h2);
        tick();
        check_eq("wr_lgid_b",   32'(last_grant_id),  32'h1);
        check_eq("wr_dvalid_b", 32'(req_data_valid), 32'h2);

        // Slot 0 stalls then drops; slot 1 takes over (pointer at 2)
        req_valid = 4'b0001;
        mem_ready = 1'b0;
        #1;
        check_eq("dr_mvalid", 32'(mem_valid), 32'h1);
        check_eq("dr_addr",   32'(mem_addr),  32'h010);
        check_eq("dr_ready",  32'(req_ready), 32'h0);
        tick();
        check_eq("dr_dvalid_a", 32'(req_data_valid), 32'h0);
        req_valid = 4'b0010;
        mem_ready = 1'b1;
        #1 check_eq("dr_ready_b", 32'(req_ready), 32'h2);
        tick();
        check_eq("dr_dvalid_b", 32'(req_data_valid), 32'h2);
        check_eq("dr_lgid_b",   32'(last_grant_id),  32'h1);
        // Pointer now 2: slot 2 beats slot 1
        req_valid = 4'b0110;
        #1 check_eq("dr_ptr2_ready", 32'(req_ready), 32'h4);
        tick();
        check_eq("dr_ptr2_lgid", 32'(last_grant_id), 32'h2);
        // Idle: address follows pointer (now 3)
        req_valid = 4'b0000;
        #1;
        check_eq("idle_mvalid", 32'(mem_valid), 32'h0);
        check_eq("idle_addr",   32'(mem_addr),  32'h040);
        check_eq("idle_ready",  32'(req_ready), 32'h0);
        tick();
        check_eq("idle_dvalid", 32'(req_data_valid), 32'h0);
        check_eq("idle_busy",   32'(busy),           32'h0);

        // Reset right after a handshake (slot 2, pointer 3)
        req_valid = 4'b0100;
        tick();
        check_eq("ar_dvalid_pre", 32'(req_data_valid), 32'h4);
        check_eq("ar_busy_pre",   32'(busy),           32'h1);
        check_eq("ar_lgid_pre",   32'(last_grant_id),  32'h2);
        req_valid = 4'hF;
        rst_n = 1'b0;
        #1;
        check_eq("ar_dvalid", 32'(req_data_valid), 32'h0);
        check_eq("ar_busy",   32'(busy),           32'h0);
        check_eq("ar_lgid",   32'(last_grant_id),  32'h0);
        check_eq("ar_ready",  32'(req_ready),      32'h0);
        check_eq("ar_mvalid", 32'(mem_valid),      32'h0);
        tick();
        rst_n = 1'b1;
        req_valid = 4'b0000;
        tick();
        check_eq("ar_no_strobe", 32'(req_data_valid), 32'h0);
        req_valid = 4'hF;
        #1;
        check_eq("ar_ptr0_ready", 32'(req_ready), 32'h1);
        check_eq("ar_ptr0_addr",  32'(mem_addr),  32'h010);
        tick();
        check_eq("ar_ptr0_dvalid", 32'(req_data_valid), 32'h1);

`ifdef REGEX_IMEM_ARB_STATS_EN
        // Saturation and clear priority on slot 0
        req_valid   = 4'b0001;
        stats_clear = 1'b1;
        tick();
        stats_clear = 1'b0;
        check_eq("st_cleared", 32'(grant_count[SW-1:0]), 32'h0);
        for (int k = 0; k < 70000; k++) begin
            @(posedge clk);
        end
        #1;
        check_eq("st_sat",   32'(grant_count[SW-1:0]),    32'hFFFF);
        check_eq("st_slot1", 32'(grant_count[2*SW-1:SW]), 32'h0);
        stats_clear = 1'b1;
        tick();
        stats_clear = 1'b0;
        check_eq("st_clr_wins", 32'(grant_count[SW-1:0]), 32'h0);
        req_valid = 4'b0000;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
